// File: rtl/aoc_day1_pkg.sv
// Shared definitions for the day-1 command parser.
//   ASCII_*        : byte constants recognised by the parser
//   parse_state_e  : parser FSM state encoding
//   rot_cmd_t      : one rotation command {dir_r, amount} at the default amount width
//   is_digit()     : true for '0'..'9'
package aoc_day1_pkg;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_NL = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    localparam int unsigned CMD_AMT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIGITS = 3'd1,
        ST_EMIT   = 3'd2,
        ST_SKIP   = 3'd3,
        ST_FIN    = 3'd4
    } parse_state_e;

    typedef struct packed {
        logic                 dir_r;
        logic [CMD_AMT_W-1:0] amount;
    } rot_cmd_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/aoc_day1_cmd_parser_dec_accum.sv
// Decimal accumulate step: sum_c = acc_i*10 + digit_i, truncated to W bits.
//   acc_i   : current accumulator
//   digit_i : decimal digit 0..9
//   sum_c   : truncated result (combinational)
//   ovf_c   : true result did not fit in W bits (combinational)
module aoc_dec_accum #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] acc_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] sum_c,
    output logic         ovf_c
);

    // acc*10+9 < 2^(W+4), so four guard bits hold the exact result
    localparam int unsigned XW = W + 4;

    logic [XW-1:0] ext;
    logic [XW-1:0] wide;

    // Shift-add form of multiply-by-ten
    always_comb begin
        ext  = XW'(acc_i);
        wide = (ext << 3) + (ext << 1) + XW'(digit_i);
    end

    assign sum_c = wide[W-1:0];
    assign ovf_c = |wide[XW-1:W];

endmodule

// File: rtl/aoc_day1_cmd_parser.sv
// ASCII puzzle-input parser: turns "L68\nR48\n..." into rotation commands.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   in_byte/in_valid/in_last: byte stream input, in_ready = byte accepted
//   cmd_amount/cmd_dir_r    : command payload, cmd_valid/cmd_ready handshake
//   cmd_count/err_count     : commands consumed / malformed lines dropped
//   overflow                : sticky, an amount exceeded AMT_W bits
//   done                    : sticky, file parsed and last command consumed
// Build option: define AOC_PARSER_CRLF_EN to ignore '\r' outside SKIP.
module aoc_day1_cmd_parser #(
    parameter int unsigned AMT_W = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [AMT_W-1:0] cmd_amount,
    output logic             cmd_dir_r,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count,
    output logic             overflow,
    output logic             done
);

    import aoc_day1_pkg::*;

    parse_state_e     state_q, state_d;
    logic             dir_q, dir_d;
    logic [AMT_W-1:0] acc_q, acc_d;
    logic             seen_q, seen_d;
    logic             last_q, last_d;
    logic [AMT_W-1:0] cmd_amount_q, cmd_amount_d;
    logic             cmd_dir_q, cmd_dir_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [AMT_W-1:0] acc_sum_c;
    logic             acc_ovf_c;

    aoc_dec_accum #(
        .W       (AMT_W)
    ) u_dec_accum (
        .acc_i   (acc_q),
        .digit_i (in_byte[3:0]),
        .sum_c   (acc_sum_c),
        .ovf_c   (acc_ovf_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            acc_q        <= '0;
            seen_q       <= 1'b0;
            last_q       <= 1'b0;
            cmd_amount_q <= '0;
            cmd_dir_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            cmd_count_q  <= '0;
            err_count_q  <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            acc_q        <= acc_d;
            seen_q       <= seen_d;
            last_q       <= last_d;
            cmd_amount_q <= cmd_amount_d;
            cmd_dir_q    <= cmd_dir_d;
            cmd_valid_q  <= cmd_valid_d;
            in_ready_q   <= in_ready_d;
            cmd_count_q  <= cmd_count_d;
            err_count_q  <= err_count_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    logic         byte_fire;
    logic         is_nl;
    logic         is_dig;
    logic         is_dir;
    logic         cr_ign;
    logic         err_inc;
    parse_state_e nxt;

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        acc_d        = acc_q;
        seen_d       = seen_q;
        last_d       = last_q;
        cmd_amount_d = cmd_amount_q;
        cmd_dir_d    = cmd_dir_q;
        cmd_count_d  = cmd_count_q;
        overflow_d   = overflow_q;
        err_inc      = 1'b0;
        nxt          = state_q;

        byte_fire = in_valid && in_ready_q;
        is_nl     = (in_byte == ASCII_NL);
        is_dig    = is_digit(in_byte);
        is_dir    = (in_byte == ASCII_L) || (in_byte == ASCII_R);
`ifdef AOC_PARSER_CRLF_EN
        cr_ign    = (in_byte == ASCII_CR);
`else
        cr_ign    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (byte_fire && !cr_ign && !is_nl) begin
                    if (is_dir) begin
                        dir_d  = (in_byte == ASCII_R);
                        acc_d  = '0;
                        seen_d = 1'b0;
                        nxt    = ST_DIGITS;
                    end else begin
                        err_inc = 1'b1;
                        nxt     = ST_SKIP;
                    end
                end
            end
            ST_DIGITS: begin
                if (byte_fire && !cr_ign) begin
                    if (is_dig) begin
                        acc_d  = acc_sum_c;
                        seen_d = 1'b1;
                        if (acc_ovf_c) begin
                            overflow_d = 1'b1;
                        end
                    end else if (is_nl) begin
                        if (seen_q) begin
                            nxt = ST_EMIT;
                        end else begin
                            err_inc = 1'b1;
                            nxt     = ST_IDLE;
                        end
                    end else begin
                        err_inc = 1'b1;
                        nxt     = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (byte_fire && is_nl) begin
                    nxt = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (cmd_ready) begin
                    cmd_count_d = cmd_count_q + CNT_W'(1);
                    last_d      = 1'b0;
                    nxt         = last_q ? ST_FIN : ST_IDLE;
                end
            end
            ST_FIN: begin
                nxt = ST_FIN;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase

        // Final byte: close any open line, then head for FIN
        state_d = nxt;
        if (byte_fire && in_last) begin
            case (nxt)
                ST_DIGITS: begin
                    if (seen_d) begin
                        state_d = ST_EMIT;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_FIN;
                    end
                end
                ST_EMIT: state_d = ST_EMIT;
                default: state_d = ST_FIN;
            endcase
            last_d = (state_d == ST_EMIT);
        end

        // Capture the command payload on entry to EMIT
        if ((state_d == ST_EMIT) && (state_q != ST_EMIT)) begin
            cmd_amount_d = acc_d;
            cmd_dir_d    = dir_d;
        end

        err_count_d = err_count_q + CNT_W'(err_inc);
        cmd_valid_d = (state_d == ST_EMIT);
        done_d      = (state_d == ST_FIN);
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_DIGITS) || (state_d == ST_SKIP);
    end

    assign in_ready   = in_ready_q;
    assign cmd_amount = cmd_amount_q;
    assign cmd_dir_r  = cmd_dir_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_count  = cmd_count_q;
    assign err_count  = err_count_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aoc_day1_cmd_parser.sv
// Directed testbench for aoc_day1_cmd_parser (default AMT_W = CNT_W = 32).
module tb_aoc_day1_cmd_parser;

    import aoc_day1_pkg::*;

    localparam int unsigned AMT_W    = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int          WAIT_MAX = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [AMT_W-1:0] cmd_amount;
    logic             cmd_dir_r;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count;
    logic [CNT_W-1:0] err_count;
    logic             overflow;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    rot_cmd_t got_q[$];
    rot_cmd_t exp_q[$];

    aoc_day1_cmd_parser #(
        .AMT_W      (AMT_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .cmd_amount (cmd_amount),
        .cmd_dir_r  (cmd_dir_r),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_count  (cmd_count),
        .err_count  (err_count),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Record every command handshake, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            got_q.push_back('{dir_r: cmd_dir_r, amount: cmd_amount});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n        = 0;
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        assert (n < WAIT_MAX) else begin
            n_fail++;
            $error("FAIL in_ready_wait: observed %0d cycles expected fewer than %0d", n, WAIT_MAX);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last && (i == s.len() - 1));
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_cmds(input string tag);
        check($sformatf("%s_ncmd", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_dir%0d", tag, i), 64'(got_q[i].dir_r), 64'(exp_q[i].dir_r));
            check($sformatf("%s_amt%0d", tag, i), 64'(got_q[i].amount), 64'(exp_q[i].amount));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),   64'd1);
        check({tag, "_cmd_valid"}, 64'(cmd_valid),  64'd0);
        check({tag, "_cmd_amt"},   64'(cmd_amount), 64'd0);
        check({tag, "_cmd_dir"},   64'(cmd_dir_r),  64'd0);
        check({tag, "_cmd_cnt"},   64'(cmd_count),  64'd0);
        check({tag, "_err_cnt"},   64'(err_count),  64'd0);
        check({tag, "_ovf"},       64'(overflow),   64'd0);
        check({tag, "_done"},      64'(done),       64'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        cmd_ready = 1'b1;

        // Reset state
        do_reset();
        check_reset_vals("rst0");

        // Two LF-terminated lines, registered emit timing
        send_str("L68\n", 1'b0);
        check("t1_valid_n1", 64'(cmd_valid), 64'd1);
        check("t1_ready_n1", 64'(in_ready), 64'd0);
        check("t1_amt_n1", 64'(cmd_amount), 64'd68);
        send_str("R48\n", 1'b1);
        settle();
        exp_q.push_back('{dir_r: 1'b0, amount: 32'd68});
        exp_q.push_back('{dir_r: 1'b1, amount: 32'd48});
        check_cmds("t1");
        check("t1_cmd_cnt", 64'(cmd_count), 64'd2);
        check("t1_err_cnt", 64'(err_count), 64'd0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_fin_ready", 64'(in_ready), 64'd0);

        // Final line without newline
        do_reset();
        send_str("R5", 1'b1);
        settle();
        exp_q.push_back('{dir_r: 1'b1, amount: 32'd5});
        check_cmds("t2");
        check("t2_cmd_cnt", 64'(cmd_count), 64'd1);
        check("t2_done", 64'(done), 64'd1);

        // Bad letter, blank line, letter-only line, then a good one
        do_reset();
        send_str("X12\n\nL\nR7\n", 1'b1);
        settle();
        exp_q.push_back('{dir_r: 1'b1, amount: 32'd7});
        check_cmds("t3");
        check("t3_err_cnt", 64'(err_count), 64'd2);
        check("t3_cmd_cnt", 64'(cmd_count), 64'd1);
        check("t3_done", 64'(done), 64'd1);

        // Largest representable amount, then one past it
        do_reset();
        send_str("R4294967295\n", 1'b0);
        settle();
        check("t4_ovf_max", 64'(overflow), 64'd0);
        send_str("R4294967296\n", 1'b1);
        settle();
        exp_q.push_back('{dir_r: 1'b1, amount: 32'hFFFF_FFFF});
        exp_q.push_back('{dir_r: 1'b1, amount: 32'd0});
        check_cmds("t4");
        check("t4_ovf", 64'(overflow), 64'd1);

        // Consumer stall holds the command and back-pressures input
        do_reset();
        cmd_ready = 1'b0;
        send_str("L1\n", 1'b0);
        in_byte  = ASCII_L;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t5_valid_c%0d", k), 64'(cmd_valid), 64'd1);
            check($sformatf("t5_amt_c%0d", k), 64'(cmd_amount), 64'd1);
            check($sformatf("t5_ready_c%0d", k), 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cmd_ready = 1'b1;
        send_str("L2\n", 1'b1);
        settle();
        exp_q.push_back('{dir_r: 1'b0, amount: 32'd1});
        exp_q.push_back('{dir_r: 1'b0, amount: 32'd2});
        check_cmds("t5");
        check("t5_cmd_cnt", 64'(cmd_count), 64'd2);

        // CRLF line ending
        do_reset();
        send_str("R30", 1'b0);
        send_byte(ASCII_CR, 1'b0);
        send_str("\n", 1'b1);
        settle();
`ifdef AOC_PARSER_CRLF_EN
        exp_q.push_back('{dir_r: 1'b1, amount: 32'd30});
        check_cmds("t6");
        check("t6_err_cnt", 64'(err_count), 64'd0);
        check("t6_cmd_cnt", 64'(cmd_count), 64'd1);
`else
        check_cmds("t6");
        check("t6_err_cnt", 64'(err_count), 64'd1);
        check("t6_cmd_cnt", 64'(cmd_count), 64'd0);
`endif
        check("t6_done", 64'(done), 64'd1);

        // File ends inside a skipped line: done right after the last byte
        do_reset();
        send_str("Xq", 1'b1);
        check("t7_done_now", 64'(done), 64'd1);
        check("t7_err_cnt", 64'(err_count), 64'd1);
        check("t7_cmd_cnt", 64'(cmd_count), 64'd0);

        // Reset mid-line
        do_reset();
        send_str("R12", 1'b0);
        do_reset();
        check_reset_vals("t8_midline");

        // Asynchronous reset while a command is pending
        cmd_ready = 1'b0;
        send_str("L9\n", 1'b0);
        check("t8_emit_valid", 64'(cmd_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t8_async_valid", 64'(cmd_valid), 64'd0);
        check("t8_async_amt", 64'(cmd_amount), 64'd0);
        cmd_ready = 1'b1;
        do_reset();
        check_reset_vals("t8_midemit");
        send_str("L3\n", 1'b0);
        settle();
        exp_q.push_back('{dir_r: 1'b0, amount: 32'd3});
        check_cmds("t8");
        check("t8_cmd_cnt", 64'(cmd_count), 64'd1);
        check("t8_done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aoc_day1_cmd_parser.md
# aoc_day1_cmd_parser

Byte-stream parser that converts the raw ASCII puzzle input ("L68\nR48\n...") into rotation commands for the day-1 dial solver. It sits between the input source (UART/ROM reader, one byte per handshake) and the solver's `in_data`/`dir_r` inputs. It decodes the direction letter and the decimal amount, then presents one command per line through a valid/ready handshake. Malformed lines are dropped and counted.

## Interface
Parameters:
- `AMT_W`, default 32: width of the decoded amount; matches solver `in_data`.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`  in  1: sole clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_byte`  in  8: ASCII input byte.
- `in_valid`  in  1: `in_byte` is valid.
- `in_last`  in  1: qualifies `in_byte` as the final byte of the file.
- `in_ready`  out  1: parser accepts the byte this cycle.
- `cmd_amount`  out  AMT_W: decoded rotation amount.
- `cmd_dir_r`  out  1: 1 = 'R' (clockwise), 0 = 'L'.
- `cmd_valid`  out  1: command available.
- `cmd_ready`  in  1: consumer takes the command.
- `cmd_count`  out  CNT_W: number of commands accepted by the consumer.
- `err_count`  out  CNT_W: number of malformed lines dropped.
- `overflow`  out  1: sticky; an amount exceeded 2^AMT_W−1.
- `done`  out  1: sticky; file fully parsed and last command consumed.

## Operation
- A byte transfers when `in_valid && in_ready`. A command transfers when `cmd_valid && cmd_ready`.
- FSM states: IDLE, DIGITS, EMIT, SKIP, FIN.
- IDLE:
  - 'L' or 'R': latch direction, clear the accumulator, go to DIGITS.
  - '\n': blank line; ignored, stay in IDLE.
  - Any other byte: `err_count`+1, go to SKIP.
- DIGITS:
  - '0'–'9': acc = acc*10 + digit, truncated to AMT_W bits. If the true result exceeds AMT_W bits, set `overflow`. The command is still emitted with the truncated value.
  - '\n' with at least one digit seen: go to EMIT.
  - '\n' with no digits: `err_count`+1, go to IDLE.
  - Any other byte: `err_count`+1, go to SKIP.
- SKIP: discard bytes until '\n', then go to IDLE.
- EMIT:
  - `cmd_valid`=1 while `cmd_amount`/`cmd_dir_r` are held stable.
  - On transfer, `cmd_count`+1, then go to IDLE, or to FIN if the file has ended.
- `in_ready` = 1 in IDLE, DIGITS and SKIP; 0 in EMIT and FIN. Input is therefore back-pressured whenever a command is pending.
- End of file (`in_last` accepted):
  - The byte is first processed normally.
  - A final line without '\n' that has ≥1 digit is treated as terminated and goes to EMIT.
  - A final line with only a letter is an error.
  - Mid-line in SKIP, the line is dropped.
  - The FSM then proceeds to FIN, either after the emit completes or immediately.
- FIN: `done`=1; all input ignored until reset.
- Counters wrap at 2^CNT_W.
- Reset mid-line or mid-emit discards all state immediately; no partial command is output.

## Timing
- Terminating byte accepted in cycle N → `cmd_valid`=1 in cycle N+1 (registered). Earliest next byte acceptance is N+2, assuming `cmd_ready`=1 at N+1.
- Throughput: one byte per cycle inside a line; one bubble cycle per command.
- `cmd_*` outputs are registered; `in_ready` is decoded from state only, never from `cmd_ready`.
- `done` asserts the cycle after the final transfer, or after the final byte if nothing was pending.
- Reset values:
  - `in_ready`=1 (IDLE).
  - `cmd_valid`=0, `cmd_amount`=0, `cmd_dir_r`=0.
  - `cmd_count`=0, `err_count`=0, `overflow`=0, `done`=0.

## Configuration
- `AOC_PARSER_CRLF_EN`:
  - Defined: '\r' is ignored in every state except SKIP, so CRLF files parse identically to LF files.
  - Undefined: '\r' is an ordinary invalid byte; it counts as an error and the line is skipped.

## Structure
- Package `aoc_day1_pkg` holds:
  - ASCII constants: `ASCII_L`, `ASCII_R`, `ASCII_NL`, `ASCII_CR`, `ASCII_0`, `ASCII_9`.
  - The parser state enum.
  - A `rot_cmd_t` struct of {dir_r, amount}.
- One sub-module, `aoc_dec_accum`, performs the multiply-by-10-plus-digit step (shift-add form: acc<<3 + acc<<1 + d) and produces the overflow carry.

## Test plan
- "L68\nR48\n" with `cmd_ready`=1 → commands (0,68), (1,48); `cmd_count`=2; `done`=1 after the final byte.
- "R5" with `in_last` on '5' and no newline → one command (1,5); `done`=1.
- "X12\n\nL\nR7\n" → one command (1,7); `err_count`=2. The blank line is not an error.
- "R4294967296\n" with AMT_W=32 → `cmd_amount`=0, `overflow`=1.
- "L1\nL2\n" with `cmd_ready` held 0 for 5 cycles → `cmd_valid` stays high, `cmd_amount` is stable at 1, and `in_ready`=0. After release, (0,2) follows.
- "R30\r\n":
  - With `AOC_PARSER_CRLF_EN` defined → command (1,30), `err_count`=0.
  - Without it → no command, `err_count`=1.
- Reset asserted after "R12" → all outputs return to reset values. A subsequent "L3\n" yields (0,3).
